// File: rtl/imm_chunk_encoder.sv
// Splits a DATA_W constant into the shortest LOAD/SHLOR immediate sequence,
// skipping leading zero chunks that zero-extension already supplies.
module imm_chunk_encoder #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMM_W  = 4,
   parameter int unsigned REG_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_value,
   input  logic [REG_W-1:0]  in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_op,
   output logic [IMM_W-1:0]  out_imm,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_last,
   output logic              busy
);
   localparam int unsigned NCHUNK = DATA_W / IMM_W;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((IMM_W == 0) || (DATA_W % IMM_W != 0)) begin : g_bad_width
      $error("imm_chunk_encoder: DATA_W must be a non-zero multiple of IMM_W");
   end

   typedef enum logic {IDLE, EMIT} state_t;

   state_t            state;
   logic [DATA_W-1:0] value_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  lead;
   logic [IDX_W-1:0]  idx_next;

   function automatic logic [IMM_W-1:0] chunk(input logic [DATA_W-1:0] v,
                                              input logic [IDX_W-1:0]  k);
      return v[k*IMM_W +: IMM_W];
   endfunction

   // Highest non-zero chunk of the incoming constant; 0 when the constant is 0.
   always_comb begin
      lead = '0;
      for (int unsigned k = 0; k < NCHUNK; k++) begin
         if (in_value[k*IMM_W +: IMM_W] != '0) lead = IDX_W'(k);
      end
   end

   assign idx_next = idx_q - 1'b1;

   // Output fields are loaded one cycle ahead so every out_* comes from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_op    <= 1'b0;
         out_imm   <= '0;
         out_rd    <= '0;
         out_last  <= 1'b0;
         idx_q     <= '0;
         value_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  value_q   <= in_value;
                  idx_q     <= lead;
                  out_rd    <= in_rd;
                  out_op    <= 1'b0;
                  out_imm   <= chunk(in_value, lead);
                  out_last  <= (lead == '0);
                  out_valid <= 1'b1;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= EMIT;
               end
            end
            EMIT: begin
               if (out_valid && out_ready) begin
                  if (idx_q == '0) begin
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     idx_q    <= idx_next;
                     out_op   <= 1'b1;
                     out_imm  <= chunk(value_q, idx_next);
                     out_last <= (idx_next == '0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imm_chunk_encoder.sv
// Randomized bench for imm_chunk_encoder: an 8-bit and a 16-bit instance are
// checked against an arithmetic chunk model plus a shift/or register rebuild.
module tb_imm_chunk_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_op, a_out_last, a_busy;
   logic [7:0] a_in_value;
   logic [1:0] a_in_rd, a_out_rd;
   logic [3:0] a_out_imm;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_op, b_out_last, b_busy;
   logic [15:0] b_in_value;
   logic [1:0]  b_in_rd, b_out_rd;
   logic [3:0]  b_out_imm;

   int n_checks = 0;
   int n_fail   = 0;

   imm_chunk_encoder #(.DATA_W(8), .IMM_W(4), .REG_W(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_value(a_in_value), .in_rd(a_in_rd),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_op(a_out_op),
      .out_imm(a_out_imm), .out_rd(a_out_rd), .out_last(a_out_last), .busy(a_busy)
   );

   imm_chunk_encoder #(.DATA_W(16), .IMM_W(4), .REG_W(2)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_value(b_in_value), .in_rd(b_in_rd),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_op(b_out_op),
      .out_imm(b_out_imm), .out_rd(b_out_rd), .out_last(b_out_last), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Packed view {out_valid, in_ready, busy, op, imm[3:0], rd[1:0], last}
   function automatic logic [10:0] obs(input bit wide);
      if (wide) return {b_out_valid, b_in_ready, b_busy, b_out_op, b_out_imm, b_out_rd, b_out_last};
      return {a_out_valid, a_in_ready, a_busy, a_out_op, a_out_imm, a_out_rd, a_out_last};
   endfunction

   task automatic drive(input bit wide, input logic v, input logic [15:0] val,
                        input logic [1:0] rd, input logic ordy);
      if (wide) begin
         b_in_valid = v; b_in_value = val; b_in_rd = rd; b_out_ready = ordy;
      end else begin
         a_in_valid = v; a_in_value = val[7:0]; a_in_rd = rd; a_out_ready = ordy;
      end
   endtask

   // mode: 0 = out_ready high, 1 = 3-cycle stall per word, 2 = random ready,
   //       3 = async reset after the first word
   task automatic run_seq(input bit wide, input logic [15:0] value_in,
                          input logic [1:0] rd, input int mode);
      logic [15:0] value, v, recon;
      logic [7:0]  words[$];
      logic [10:0] o;
      logic        ordy;
      int          n, j, cyc, stall, w;
      value = wide ? value_in : {8'h00, value_in[7:0]};
      n = 1;
      v = value >> 4;
      while (v != 0) begin
         n++;
         v = v >> 4;
      end
      for (int i = 0; i < n; i++) begin
         logic [15:0] c;
         c = (value >> ((n - 1 - i) * 4)) & 16'h000F;
         words.push_back({(i != 0) ? 1'b1 : 1'b0, c[3:0], rd, (i == n - 1) ? 1'b1 : 1'b0});
      end

      o = obs(wide);
      w = 0;
      while (!o[9] && w < 10) begin
         @(negedge clk);
         o = obs(wide);
         w++;
      end
      check("accept_ready", {63'd0, o[9]}, 64'd1);
      drive(wide, 1'b1, value, rd, 1'b0);
      @(negedge clk);

      j = 0; cyc = 0; stall = 0; recon = '0;
      while (j < n && cyc < 64) begin
         if (mode == 3 && j == 1) begin
            #2 rst_n = 1'b0;
            #1 check("async_reset", {53'd0, obs(wide)}, {53'd0, 11'b010_0_0000_00_0});
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (mode == 1)      ordy = (stall == 3);
         else if (mode == 2) ordy = 1'($urandom_range(0, 1));
         else                ordy = 1'b1;
         drive(wide, (mode == 0 || mode == 3) ? 1'b0 : 1'($urandom_range(0, 1)),
               16'($urandom), 2'($urandom), ordy);
         o = obs(wide);
         check($sformatf("word%0d_v%0h", j, value), {53'd0, o}, {53'd0, 3'b101, words[j]});
         if (ordy) begin
            recon = o[7] ? ((recon << 4) | {12'd0, o[6:3]}) : {12'd0, o[6:3]};
            j++;
            stall = 0;
         end else begin
            stall++;
         end
         @(negedge clk);
         cyc++;
      end
      if (j < n) check("word_timeout", 64'(j), 64'(n));
      drive(wide, 1'b0, 16'h0, 2'd0, 1'b0);
      check($sformatf("recon_v%0h", value), {48'd0, recon}, {48'd0, value});
      o = obs(wide);
      check("back_to_idle", {61'd0, o[10:8]}, 64'b010);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r;
      drive(1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
      drive(1'b1, 1'b0, 16'h0, 2'd0, 1'b0);
      #12;
      check("reset8",  {53'd0, obs(1'b0)}, {53'd0, 11'b010_0_0000_00_0});
      check("reset16", {53'd0, obs(1'b1)}, {53'd0, 11'b010_0_0000_00_0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_seq(1'b0, 16'h0005, 2'd2, 0);
      run_seq(1'b0, 16'h00A3, 2'd1, 0);
      run_seq(1'b0, 16'h0000, 2'd3, 0);
      run_seq(1'b0, 16'h0030, 2'd2, 0);
      run_seq(1'b0, 16'h00A3, 2'd1, 1);
      run_seq(1'b0, 16'h00A3, 2'd1, 3);
      run_seq(1'b0, 16'h0007, 2'd0, 0);
      run_seq(1'b1, 16'h0F20, 2'd2, 0);
      run_seq(1'b1, 16'hFFFF, 2'd1, 0);
      run_seq(1'b1, 16'h0000, 2'd0, 2);
      run_seq(1'b1, 16'h1000, 2'd3, 1);

      for (int i = 0; i < 40; i++) begin
         r = $urandom;
         run_seq(1'b0, r[15:0] >> $urandom_range(0, 8), r[17:16], 2);
      end
      for (int i = 0; i < 30; i++) begin
         r = $urandom;
         run_seq(1'b1, r[15:0] >> $urandom_range(0, 16), r[17:16], (i % 3 == 0) ? 1 : 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/imm_chunk_encoder.md
Name: imm_chunk_encoder

Overview:
- Inverse of the zero-extending immediate path: takes a full-width constant and emits the shortest sequence of narrow-immediate instruction words that rebuild it in a register.
- Sits between the program/constant generator (golden-model stimulus or assembler front end) and the instruction stream fed to the CPU.
- Words use two ops:
  - LOAD: rd = zext(imm).
  - SHLOR: rd = (rd << IMM_W) | zext(imm).
- Leading zero chunks are skipped, because zero-extension already supplies them.

Parameters:
- DATA_W, 8, width of the constant; must be an integer multiple of IMM_W (elaboration-time assertion).
- IMM_W, 4, width of one immediate chunk.
- REG_W, 2, width of the destination register address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_value  input  DATA_W  constant to encode.
- in_rd  input  REG_W  destination register.
- out_valid  output  1  instruction word present.
- out_ready  input  1  consumer accepts word.
- out_op  output  1  0 = LOAD, 1 = SHLOR.
- out_imm  output  IMM_W  immediate chunk.
- out_rd  output  REG_W  destination register (registered copy of in_rd).
- out_last  output  1  final word of the sequence.
- busy  output  1  sequence in progress (state != IDLE).

Behaviour:
- Definitions:
  - NCHUNK = DATA_W/IMM_W.
  - chunk[k] = value[k*IMM_W +: IMM_W], where k = NCHUNK-1 is the most significant chunk.
- Reset (asynchronous, rst_n low):
  - State IDLE, in_ready=1, out_valid=0, busy=0.
  - out_op=0, out_imm=0, out_rd=0, out_last=0, internal index=0, value register=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready:
    - Register in_value and in_rd.
    - Set idx = lead, the highest k with chunk[k]!=0, or 0 when in_value==0.
    - Set op=LOAD and go to EMIT.
    - Inputs are sampled only on this cycle.
- State EMIT:
  - in_ready=0, out_valid=1.
  - out_imm=chunk[idx], out_last=(idx==0).
  - out_op=LOAD on the first word, SHLOR on all later words.
- Output handshake (out_valid&&out_ready):
  - If idx==0: go to IDLE; out_valid drops and in_ready rises next cycle.
  - Otherwise: idx decrements and op becomes SHLOR.
- Backpressure: while out_valid&&!out_ready, all out_* hold stable. No word is dropped or duplicated.
- Latency: the first word is valid the cycle after input acceptance.
- Throughput:
  - Sequence length = lead+1 words, from 1 to NCHUNK.
  - Minimum period per request = words+1 cycles, because there is one IDLE cycle between requests.
- in_valid during EMIT is ignored, since in_ready=0. The upstream block must hold its request.
- rst_n asserted mid-sequence aborts immediately to the reset values. No partial sequence resumes.
- All outputs are driven from registers. There is no combinational path from in_* to out_*.

Test Plan:
1. in_value=0x05, in_rd=2, out_ready=1 -> one word: op=LOAD, imm=5, rd=2, last=1, one cycle after accept; in_ready high again 2 cycles after accept.
2. in_value=0xA3, in_rd=1 -> LOAD imm=0xA last=0, then SHLOR imm=0x3 last=1; the reconstructed register equals 0xA3.
3. in_value=0x00 -> single LOAD imm=0 last=1. in_value=0x30 -> LOAD 3, SHLOR 0 (the trailing zero chunk is still emitted).
4. in_value=0xA3 with out_ready low for 3 cycles on each word -> out_imm/out_op/out_last stable throughout the stall; exactly 2 words are transferred; in_valid pulsed during EMIT is not accepted.
5. rst_n pulsed low asynchronously between the LOAD and SHLOR words of 0xA3 -> outputs reach reset values without waiting for a clock edge; the next request 0x07 yields a single LOAD 7.
6. Parameters DATA_W=16, IMM_W=4: in_value=0x0F20 -> LOAD F, SHLOR 2, SHLOR 0 (last=1); in_value=0xFFFF -> 4 words, and a model-side shift/or reconstruction matches 0xFFFF.
